xor_stream_ctrl: RTL

//  Sequences an external 64-bit combinational XOR decode datapath over a stream of ciphertext blocks.

---
 rtl/xor_stream_if.sv | 29 ++
 rtl/xor_stream_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/xor_stream_if.sv
// Handshake bundle for xor_stream_ctrl: key load, ciphertext ingress, datapath tap and plaintext egress.
// All 64-bit vectors are numbered [0:63] with bit 0 as the MSB.
interface xor_stream_if;
    logic        key_valid;
    logic [0:63] key_in;
    logic        key_ready;
    logic        key_loaded;
    logic        s_valid;
    logic [0:63] s_data;
    logic        s_last;
    logic        s_ready;
    logic [0:63] dp_data;
    logic [0:63] dp_key;
    logic [0:63] dp_result;
    logic        m_valid;
    logic [0:63] m_data;
    logic        m_last;
    logic        m_ready;

    modport slave (
        input  key_valid, key_in, s_valid, s_data, s_last, dp_result, m_ready,
        output key_ready, key_loaded, s_ready, dp_data, dp_key, m_valid, m_data, m_last
    );

    modport master (
        output key_valid, key_in, s_valid, s_data, s_last, dp_result, m_ready,
        input  key_ready, key_loaded, s_ready, dp_data, dp_key, m_valid, m_data, m_last
    );
endinterface

// File: rtl/xor_stream_ctrl.sv
// Key owner and valid/ready sequencer around an external 64-bit XOR decode datapath.
// Define XOR_KEY_ROLL_EN to rotate the active key per block and restore it at each frame end.
module xor_stream_ctrl #(
    parameter int CNT_W  = 16,
    parameter int ROLL_B = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    xor_stream_if.slave      bus,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [0:63]       base_key_r;
    logic [0:63]       active_key_s;
    logic [0:63]       m_data_r;
    logic              m_last_r;
    logic [CNT_W-1:0]  blk_cnt_r;
    logic              key_ready_s;
    logic              key_acc_s;
    logic              s_ready_s;
    logic              blk_acc_s;

    // Bit 0 is the MSB, so the low-index slice moves to the bottom of the word.
    function automatic logic [0:63] rotl(input logic [0:63] k);
        rotl = {k[ROLL_B:63], k[0:ROLL_B-1]};
    endfunction

    // Handshake qualifiers and next-state; a key load wins over a block in the same cycle.
    always_comb begin
        state_s     = state_r;
        key_ready_s = (state_r != HOLD);
        key_acc_s   = bus.key_valid & key_ready_s;
        s_ready_s   = (state_r != NOKEY) & ((state_r != HOLD) | bus.m_ready) & ~key_acc_s;
        blk_acc_s   = bus.s_valid & s_ready_s;
        case (state_r)
            NOKEY: begin
                if (key_acc_s) begin
                    state_s = RUN;
                end else begin
                    state_s = NOKEY;
                end
            end
            RUN: begin
                if (blk_acc_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = RUN;
                end
            end
            HOLD: begin
                if (bus.m_ready & ~blk_acc_s) begin
                    state_s = RUN;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = NOKEY;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= NOKEY;
        end else begin
            state_r <= state_s;
        end
    end

    // Loaded key, kept as the frame-start reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_key_r <= 64'h0;
        end else if (key_acc_s) begin
            base_key_r <= bus.key_in;
        end
    end

`ifdef XOR_KEY_ROLL_EN
    logic [0:63] active_key_r;

    // Rolling key: advances per non-last block, rewinds to the loaded key at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_key_r <= 64'h0;
        end else if (key_acc_s) begin
            active_key_r <= bus.key_in;
        end else if (blk_acc_s) begin
            if (bus.s_last) begin
                active_key_r <= base_key_r;
            end else begin
                active_key_r <= rotl(active_key_r);
            end
        end
    end

    assign active_key_s = active_key_r;
`else
    assign active_key_s = base_key_r;
`endif

    // Output stage: captures the datapath result on block accept, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r <= 64'h0;
            m_last_r <= 1'b0;
        end else if (blk_acc_s) begin
            m_data_r <= bus.dp_result;
            m_last_r <= bus.s_last;
        end
    end

    // Per-frame block counter, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_r <= {CNT_W{1'b0}};
        end else if (key_acc_s) begin
            blk_cnt_r <= {CNT_W{1'b0}};
        end else if (blk_acc_s) begin
            if (bus.s_last) begin
                blk_cnt_r <= {CNT_W{1'b0}};
            end else if (blk_cnt_r != {CNT_W{1'b1}}) begin
                blk_cnt_r <= blk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.key_ready  = key_ready_s;
    assign bus.key_loaded = (state_r != NOKEY);
    assign bus.s_ready    = s_ready_s;
    assign bus.dp_data    = bus.s_data;
    assign bus.dp_key     = active_key_s;
    assign bus.m_valid    = (state_r == HOLD);
    assign bus.m_data     = m_data_r;
    assign bus.m_last     = m_last_r;
    assign blk_cnt        = blk_cnt_r;

endmodule
